// File: rtl/rename_dispatch_pkg.sv
// rename_dispatch_pkg
// Shared widths, the invalid-tag encoding, the operand record used by the
// rename table and the issue packet, and the operand resolution helper.
package rename_dispatch_pkg;

  localparam int COMMON_W   = 32;
  localparam int REG_W      = 5;
  localparam int TAG_W      = 5;
  localparam int ROB_N      = 16;
  localparam int OP_W       = 8;
  localparam int NUM_REGS   = 32;
  localparam int ROB_IDX_W  = 4;

  localparam logic [TAG_W-1:0] TAG_INVALID = 5'h10;

  typedef logic [ROB_N-1:0][COMMON_W-1:0] bc_vals_t;

  // Resolved source operand: q == TAG_INVALID means v holds the real value.
  typedef struct packed {
    logic [COMMON_W-1:0] v;
    logic [TAG_W-1:0]    q;
  } operand_t;

  // Priority: x0, then committed file value, then same-cycle commit, then
  // ROB broadcast, otherwise the operand stays pending on its producer tag.
  // A live status tag is always below ROB_N, so its low bits index the ROB.
  function automatic operand_t resolve_operand(
    input logic [REG_W-1:0]    rs,
    input logic [TAG_W-1:0]    status_tag,
    input logic [COMMON_W-1:0] file_val,
    input logic [TAG_W-1:0]    wb_tag,
    input logic [COMMON_W-1:0] wb_data,
    input logic [ROB_N-1:0]    bc_ready,
    input bc_vals_t            bc_val
  );
    operand_t             res;
    logic [ROB_IDX_W-1:0] idx;
    idx   = status_tag[ROB_IDX_W-1:0];
    res.v = '0;
    res.q = TAG_INVALID;
    if (rs == '0) begin
      res.v = '0;
      res.q = TAG_INVALID;
    end else if (status_tag == TAG_INVALID) begin
      res.v = file_val;
    end else if (wb_tag == status_tag) begin
      res.v = wb_data;
    end else if (bc_ready[idx]) begin
      res.v = bc_val[idx];
    end else begin
      res.q = status_tag;
    end
    return res;
  endfunction

endpackage

// File: rtl/rename_dispatch_if.sv
// rename_dispatch_if
// Bundles the decode, ROB allocation, ROB broadcast, commit and issue
// signals of the rename/dispatch stage.
//   slave  : the rename_dispatch stage itself
//   master : the surrounding pipeline (decode, ROB, reservation station)
interface rename_dispatch_if import rename_dispatch_pkg::*; ();

  logic                dec_valid;
  logic                dec_ready;
  logic [REG_W-1:0]    dec_rd;
  logic [REG_W-1:0]    dec_rs1;
  logic [REG_W-1:0]    dec_rs2;
  logic [OP_W-1:0]     dec_op;
  logic                dec_wr;

  logic                rob_full;
  logic [TAG_W-1:0]    rob_avail_tag;
  logic                alloc_valid;
  logic [REG_W-1:0]    alloc_rd;
  logic [OP_W-1:0]     alloc_op;

  logic [ROB_N-1:0]    bc_ready;
  bc_vals_t            bc_val;

  logic [TAG_W-1:0]    wb_tag;
  logic [REG_W-1:0]    wb_rd;
  logic [COMMON_W-1:0] wb_data;

  logic                iss_valid;
  logic                iss_ready;
  logic [OP_W-1:0]     iss_op;
  logic [TAG_W-1:0]    iss_tag;
  logic [REG_W-1:0]    iss_rd;
  logic [COMMON_W-1:0] iss_v1;
  logic [COMMON_W-1:0] iss_v2;
  logic [TAG_W-1:0]    iss_q1;
  logic [TAG_W-1:0]    iss_q2;

  modport slave (
    input  dec_valid, dec_rd, dec_rs1, dec_rs2, dec_op, dec_wr,
    input  rob_full, rob_avail_tag, bc_ready, bc_val,
    input  wb_tag, wb_rd, wb_data, iss_ready,
    output dec_ready, alloc_valid, alloc_rd, alloc_op,
    output iss_valid, iss_op, iss_tag, iss_rd, iss_v1, iss_v2, iss_q1, iss_q2
  );

  modport master (
    output dec_valid, dec_rd, dec_rs1, dec_rs2, dec_op, dec_wr,
    output rob_full, rob_avail_tag, bc_ready, bc_val,
    output wb_tag, wb_rd, wb_data, iss_ready,
    input  dec_ready, alloc_valid, alloc_rd, alloc_op,
    input  iss_valid, iss_op, iss_tag, iss_rd, iss_v1, iss_v2, iss_q1, iss_q2
  );

endinterface

// File: rtl/rename_table.sv
// rename_table
// Architectural value file plus per-register pending-tag status file.
//   rs1/rs2, op1/op2      : two combinational resolve ports
//   ren_en/ren_rd/ren_tag : rename port, points a register at a new producer
//   wb_tag/wb_rd/wb_data  : commit port, also used for same-cycle forwarding
//   bc_ready/bc_val       : ROB result broadcast used during resolution
module rename_table import rename_dispatch_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rs2,
  output operand_t            op1,
  output operand_t            op2,
  input  logic                ren_en,
  input  logic [REG_W-1:0]    ren_rd,
  input  logic [TAG_W-1:0]    ren_tag,
  input  logic [TAG_W-1:0]    wb_tag,
  input  logic [REG_W-1:0]    wb_rd,
  input  logic [COMMON_W-1:0] wb_data,
  input  logic [ROB_N-1:0]    bc_ready,
  input  bc_vals_t            bc_val
);

  logic [COMMON_W-1:0] reg_file   [NUM_REGS];
  logic [TAG_W-1:0]    reg_status [NUM_REGS];
  logic                commit_en;
  logic                rename_en;

  assign commit_en = (wb_tag != TAG_INVALID) && (wb_rd != '0);
  assign rename_en = ren_en && (ren_rd != '0);

  // Sources read the status as it stood before this cycle's rename.
  always_comb begin
    op1 = resolve_operand(rs1, reg_status[rs1], reg_file[rs1],
                          wb_tag, wb_data, bc_ready, bc_val);
    op2 = resolve_operand(rs2, reg_status[rs2], reg_file[rs2],
                          wb_tag, wb_data, bc_ready, bc_val);
  end

  // Rename is applied after commit so it wins a same-register collision;
  // the commit still lands its value in the file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_file[i]   <= '0;
        reg_status[i] <= TAG_INVALID;
      end
    end else begin
      if (commit_en) begin
        reg_file[wb_rd] <= wb_data;
        if (reg_status[wb_rd] == wb_tag) begin
          reg_status[wb_rd] <= TAG_INVALID;
        end
      end
      if (rename_en) begin
        reg_status[ren_rd] <= ren_tag;
      end
    end
  end

endmodule

// File: rtl/rename_dispatch.sv
// rename_dispatch
// Accepts one decoded instruction per cycle, allocates a ROB entry, renames
// its destination and registers a one-cycle-latency issue packet.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : decode / ROB / broadcast / commit / issue signals
module rename_dispatch import rename_dispatch_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  rename_dispatch_if.slave bus
);

  logic                dispatch;
  logic [REG_W-1:0]    dest_rd;
  operand_t            op1;
  operand_t            op2;

  logic                iss_valid_q;
  logic [OP_W-1:0]     iss_op_q;
  logic [TAG_W-1:0]    iss_tag_q;
  logic [REG_W-1:0]    iss_rd_q;
  operand_t            iss_src1_q;
  operand_t            iss_src2_q;

  // A held packet blocks new dispatches; rst suppresses the alloc pulse.
  assign bus.dec_ready   = !bus.rob_full && (!iss_valid_q || bus.iss_ready);
  assign dispatch        = bus.dec_valid && bus.dec_ready && !rst;
  assign dest_rd         = bus.dec_wr ? bus.dec_rd : '0;

  assign bus.alloc_valid = dispatch;
  assign bus.alloc_rd    = dest_rd;
  assign bus.alloc_op    = bus.dec_op;

  rename_table u_table (
    .clk      (clk),
    .rst      (rst),
    .rs1      (bus.dec_rs1),
    .rs2      (bus.dec_rs2),
    .op1      (op1),
    .op2      (op2),
    .ren_en   (dispatch && bus.dec_wr),
    .ren_rd   (bus.dec_rd),
    .ren_tag  (bus.rob_avail_tag),
    .wb_tag   (bus.wb_tag),
    .wb_rd    (bus.wb_rd),
    .wb_data  (bus.wb_data),
    .bc_ready (bus.bc_ready),
    .bc_val   (bus.bc_val)
  );

  // Issue register: loads on dispatch, holds while stalled, and drops valid
  // after a handshake with nothing new behind it. Pending operands are not
  // re-resolved while held; the reservation station snoops the broadcast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_q  <= 1'b0;
      iss_op_q     <= '0;
      iss_tag_q    <= '0;
      iss_rd_q     <= '0;
      iss_src1_q.v <= '0;
      iss_src1_q.q <= TAG_INVALID;
      iss_src2_q.v <= '0;
      iss_src2_q.q <= TAG_INVALID;
    end else if (dispatch) begin
      iss_valid_q <= 1'b1;
      iss_op_q    <= bus.dec_op;
      iss_tag_q   <= bus.rob_avail_tag;
      iss_rd_q    <= dest_rd;
      iss_src1_q  <= op1;
      iss_src2_q  <= op2;
    end else if (iss_valid_q && bus.iss_ready) begin
      iss_valid_q <= 1'b0;
    end
  end

  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_op    = iss_op_q;
  assign bus.iss_tag   = iss_tag_q;
  assign bus.iss_rd    = iss_rd_q;
  assign bus.iss_v1    = iss_src1_q.v;
  assign bus.iss_q1    = iss_src1_q.q;
  assign bus.iss_v2    = iss_src2_q.v;
  assign bus.iss_q2    = iss_src2_q.q;

endmodule

// File: tb/tb_rename_dispatch.sv
// tb_rename_dispatch
// Directed bench for rename_dispatch: reset state, dispatch/alloc, operand
// resolution paths, commit forwarding, rename/commit collision, issue hold,
// ROB-full stall, x0 handling and reset during a held packet.
module tb_rename_dispatch;
  import rename_dispatch_pkg::*;

  logic clk;
  logic rst;
  int   checks_total;
  int   checks_passed;

  rename_dispatch_if bus ();

  rename_dispatch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here so both counters stay in step.
  task automatic checkOutput(input string name, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks_total = checks_total + 1;
    assert (obs === exp) checks_passed = checks_passed + 1;
    else $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [7:0] op, input logic wr,
                               input logic [4:0] tag);
    bus.dec_valid     = valid;
    bus.dec_rd        = rd;
    bus.dec_rs1       = rs1;
    bus.dec_rs2       = rs2;
    bus.dec_op        = op;
    bus.dec_wr        = wr;
    bus.rob_avail_tag = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst           = 1'b1;
    bus.rob_full  = 1'b0;
    bus.bc_ready  = '0;
    bus.bc_val    = '0;
    bus.wb_tag    = TAG_INVALID;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.iss_ready = 1'b1;
    applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 8'h01, 1'b1, 5'd2);

    // Reset state, with a decode request present that must not allocate.
    step();
    step();
    checkOutput("rst_iss_valid", bus.iss_valid, 0);
    checkOutput("rst_iss_q1", bus.iss_q1, TAG_INVALID);
    checkOutput("rst_iss_q2", bus.iss_q2, TAG_INVALID);
    checkOutput("rst_iss_v1", bus.iss_v1, 0);
    checkOutput("rst_iss_tag", bus.iss_tag, 0);
    checkOutput("rst_alloc_valid", bus.alloc_valid, 0);
    rst = 1'b0;

    // add x3 <- x0,x0 with tag 2.
    #1;
    checkOutput("d1_dec_ready", bus.dec_ready, 1);
    checkOutput("d1_alloc_valid", bus.alloc_valid, 1);
    checkOutput("d1_alloc_rd", bus.alloc_rd, 3);
    checkOutput("d1_alloc_op", bus.alloc_op, 8'h01);
    step();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 1'b0, 5'd0);
    #1;
    checkOutput("d1_alloc_pulse_end", bus.alloc_valid, 0);
    checkOutput("d1_iss_valid", bus.iss_valid, 1);
    checkOutput("d1_iss_tag", bus.iss_tag, 2);
    checkOutput("d1_iss_rd", bus.iss_rd, 3);
    checkOutput("d1_iss_q1", bus.iss_q1, TAG_INVALID);
    checkOutput("d1_iss_q2", bus.iss_q2, TAG_INVALID);
    checkOutput("d1_iss_v1", bus.iss_v1, 0);
    checkOutput("d1_iss_v2", bus.iss_v2, 0);

    // x4 <- x3 while x3 waits on tag 2, no broadcast: stays pending.
    applyStimulus(1'b1, 5'd4, 5'd3, 5'd0, 8'h02, 1'b1, 5'd3);
    step();
    checkOutput("pend_iss_q1", bus.iss_q1, 2);
    checkOutput("pend_iss_v1", bus.iss_v1, 0);
    checkOutput("pend_iss_tag", bus.iss_tag, 3);

    // Same source with tag 2 broadcast ready; dec_wr=0 so no rename.
    bus.bc_ready[2] = 1'b1;
    bus.bc_val[2]   = 32'h55;
    applyStimulus(1'b1, 5'd9, 5'd3, 5'd0, 8'h03, 1'b0, 5'd4);
    #1;
    checkOutput("bc_alloc_rd", bus.alloc_rd, 0);
    step();
    bus.bc_ready = '0;
    bus.bc_val   = '0;
    checkOutput("bc_iss_v1", bus.iss_v1, 32'h55);
    checkOutput("bc_iss_q1", bus.iss_q1, TAG_INVALID);
    checkOutput("bc_iss_rd", bus.iss_rd, 0);

    // Commit tag 2 -> x3 forwarded in the same cycle; x4 still on tag 3.
    bus.wb_tag  = 5'd2;
    bus.wb_rd   = 5'd3;
    bus.wb_data = 32'h77;
    applyStimulus(1'b1, 5'd0, 5'd3, 5'd4, 8'h04, 1'b0, 5'd5);
    step();
    bus.wb_tag = TAG_INVALID;
    checkOutput("fwd_iss_v1", bus.iss_v1, 32'h77);
    checkOutput("fwd_iss_q1", bus.iss_q1, TAG_INVALID);
    checkOutput("fwd_iss_q2", bus.iss_q2, 3);
    applyStimulus(1'b1, 5'd0, 5'd3, 5'd0, 8'h05, 1'b0, 5'd6);
    step();
    checkOutput("commit_file_v1", bus.iss_v1, 32'h77);
    checkOutput("commit_status_q1", bus.iss_q1, TAG_INVALID);

    // x3 -> tag 2, then rename x3 -> tag 5 while tag 2 commits to x3.
    applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 8'h06, 1'b1, 5'd2);
    step();
    bus.wb_tag  = 5'd2;
    bus.wb_rd   = 5'd3;
    bus.wb_data = 32'h99;
    applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 8'h07, 1'b1, 5'd5);
    step();
    bus.wb_tag = TAG_INVALID;
    applyStimulus(1'b1, 5'd0, 5'd3, 5'd0, 8'h08, 1'b0, 5'd6);
    step();
    checkOutput("collide_q1", bus.iss_q1, 5);
    checkOutput("collide_v1", bus.iss_v1, 0);
    checkOutput("collide_file", dut.u_table.reg_file[3], 32'h99);

    // Hold: packet A (waits on tag 5) stalled for 3 cycles with B waiting.
    applyStimulus(1'b1, 5'd0, 5'd3, 5'd0, 8'hAB, 1'b0, 5'd6);
    step();
    bus.iss_ready   = 1'b0;
    bus.bc_ready[5] = 1'b1;
    bus.bc_val[5]   = 32'h1234;
    applyStimulus(1'b1, 5'd7, 5'd0, 5'd0, 8'hCD, 1'b1, 5'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("hold%0d_dec_ready", i), bus.dec_ready, 0);
      checkOutput($sformatf("hold%0d_alloc", i), bus.alloc_valid, 0);
      checkOutput($sformatf("hold%0d_iss_valid", i), bus.iss_valid, 1);
      checkOutput($sformatf("hold%0d_iss_op", i), bus.iss_op, 8'hAB);
      checkOutput($sformatf("hold%0d_iss_tag", i), bus.iss_tag, 6);
      checkOutput($sformatf("hold%0d_iss_q1", i), bus.iss_q1, 5);
      step();
    end
    bus.iss_ready = 1'b1;
    #1;
    checkOutput("release_alloc", bus.alloc_valid, 1);
    step();
    bus.bc_ready = '0;
    bus.bc_val   = '0;
    checkOutput("release_iss_op", bus.iss_op, 8'hCD);
    checkOutput("release_iss_tag", bus.iss_tag, 7);
    checkOutput("release_iss_rd", bus.iss_rd, 7);

    // ROB full stalls decode.
    bus.rob_full = 1'b1;
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd0, 8'h10, 1'b1, 5'd8);
    #1;
    checkOutput("robfull_dec_ready", bus.dec_ready, 0);
    checkOutput("robfull_alloc", bus.alloc_valid, 0);
    step();
    bus.rob_full = 1'b0;

    // x0 as destination and as commit target stays zero and ready.
    bus.wb_tag  = 5'd9;
    bus.wb_rd   = 5'd0;
    bus.wb_data = 32'hDEAD;
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 8'h11, 1'b1, 5'd8);
    #1;
    checkOutput("x0_alloc_rd", bus.alloc_rd, 0);
    step();
    bus.wb_tag = TAG_INVALID;
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 8'h12, 1'b0, 5'd9);
    step();
    checkOutput("x0_iss_v1", bus.iss_v1, 0);
    checkOutput("x0_iss_q1", bus.iss_q1, TAG_INVALID);
    checkOutput("x0_iss_v2", bus.iss_v2, 0);
    checkOutput("x0_iss_q2", bus.iss_q2, TAG_INVALID);

    // Reset while a packet is held discards it and suppresses alloc.
    applyStimulus(1'b1, 5'd2, 5'd0, 5'd0, 8'h13, 1'b1, 5'd10);
    step();
    bus.iss_ready = 1'b0;
    #1;
    checkOutput("rsthold_pre_valid", bus.iss_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("rsthold_iss_valid", bus.iss_valid, 0);
    checkOutput("rsthold_iss_op", bus.iss_op, 0);
    checkOutput("rsthold_iss_q1", bus.iss_q1, TAG_INVALID);
    checkOutput("rsthold_alloc", bus.alloc_valid, 0);
    step();
    checkOutput("rsthold_alloc_edge", bus.alloc_valid, 0);
    rst           = 1'b0;
    bus.iss_ready = 1'b1;
    applyStimulus(1'b1, 5'd0, 5'd3, 5'd0, 8'h14, 1'b0, 5'd1);
    step();
    checkOutput("post_rst_v1", bus.iss_v1, 0);
    checkOutput("post_rst_q1", bus.iss_q1, TAG_INVALID);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 1'b0, 5'd0);
    step();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/rename_dispatch.md
RENAME_DISPATCH -- requirements
Module: rename_dispatch

Interface
REQ-001 clk  in  1  clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset; asynchronous, active-high.
REQ-003 dec_valid  in  1  decoded instruction present.
REQ-004 dec_ready  out  1  instruction accepted this cycle.
REQ-005 dec_rd / dec_rs1 / dec_rs2  in  5 each  register indices.
REQ-006 dec_op  in  OP_W(8)  operation code.
REQ-007 dec_wr  in  1  instruction writes rd.
REQ-008 rob_full  in  1  ROB cannot allocate.
REQ-009 rob_avail_tag  in  TAG_W(5)  tag the next allocation receives.
REQ-010 alloc_valid  out  1  single-cycle ROB allocation pulse.
REQ-011 alloc_rd  out  5  destination recorded in the ROB entry.
REQ-012 alloc_op  out  8  op recorded in the ROB entry.
REQ-013 bc_ready  in  ROB_N(16)  per-entry result-ready flags, indexed by tag.
REQ-014 bc_val  in  16x32  per-entry result values.
REQ-015 wb_tag  in  5  committing tag; TAG_INVALID (5'h10) means no commit.
REQ-016 wb_rd  in  5  commit destination.
REQ-017 wb_data  in  32  commit value.
REQ-018 iss_valid  out  1  issue packet valid.
REQ-019 iss_ready  in  1  reservation station accepts the packet.
REQ-020 iss_op, iss_tag, iss_rd  out  8/5/5  issued op, own tag, destination.
REQ-021 iss_v1, iss_v2  out  32 each  operand values.
REQ-022 iss_q1, iss_q2  out  5 each  pending producer tag, TAG_INVALID when the value is valid.

Function
REQ-023 Architectural state: 32x32 value file plus 32x5 status file holding the pending tag per register.
REQ-024 dec_ready = !rob_full && (!iss_valid || iss_ready); purely combinational.
REQ-025 Dispatch occurs when dec_valid && dec_ready.
REQ-026 On dispatch, alloc_valid=1 in the same cycle, alloc_rd = dec_wr ? dec_rd : 0, alloc_op = dec_op; otherwise alloc_valid=0.
REQ-027 Operand resolution per source rs, first match wins:
  - rs==0: v=0, q=INVALID.
  - status[rs]==INVALID: v=file[rs], q=INVALID.
  - wb_tag==status[rs]: v=wb_data, q=INVALID.
  - bc_ready[status[rs]]: v=bc_val[status[rs]], q=INVALID.
  - otherwise: v=0, q=status[rs].
REQ-028 Sources resolve against status before this instruction's own rename, so rd==rs sees the prior producer.
REQ-029 Issue latency is 1 cycle: the packet registered on the dispatch edge, iss_tag = rob_avail_tag.
REQ-030 iss_valid && !iss_ready holds every iss_* output stable; no new dispatch occurs while held.
REQ-031 A held packet with q!=INVALID is not re-resolved; the reservation station snoops the broadcast.
REQ-032 Without dispatch, iss_valid clears after a handshake (iss_valid && iss_ready).
REQ-033 Rename: on dispatch with dec_wr && dec_rd!=0, status[dec_rd] <= rob_avail_tag.
REQ-034 Commit: when wb_tag!=INVALID and wb_rd!=0, file[wb_rd] <= wb_data.
REQ-035 Commit also clears status[wb_rd] to INVALID iff status[wb_rd]==wb_tag.
REQ-036 Rename and commit to the same register in one cycle: rename wins the status update and the file is still written.
REQ-037 Register x0 is never written and its status stays INVALID.

Reset
REQ-038 rst clears all status entries to INVALID, all file entries to 0, iss_valid to 0, and all iss_* data to 0 (iss_q1/iss_q2 to INVALID).
REQ-039 rst mid-hold discards the pending packet, and no alloc_valid pulse occurs while rst is asserted.

Structure
REQ-040 The shared package holds COMMON_W=32, REG_W=5, TAG_W=5, ROB_N=16, OP_W=8 and TAG_INVALID=5'h10.
REQ-041 Value file and status file sit in one sub-module, rename_table, with two resolve ports, one rename port and one commit port; dispatch and handshake logic stay in rename_dispatch.

Verification
REQ-042 Reset, then dispatch add rd=3 rs1=0 rs2=0 with avail_tag=2 -> alloc_valid pulse; next cycle iss_tag=2, q1=q2=INVALID, v=0; status[3]=2.
REQ-043 Dispatch rs1=3 with status[3]=2, bc_ready[2]=0 -> iss_q1=2; repeat with bc_ready[2]=1 and bc_val[2]=0x55 -> iss_v1=0x55, q1=INVALID.
REQ-044 wb_tag=2, wb_rd=3, wb_data=0x77 while dispatching rs1=3 -> iss_v1=0x77; afterwards file[3]=0x77 and status[3]=INVALID.
REQ-045 Same-cycle rename of x3 to tag 5 and commit of tag 2 to x3 -> status[3]=5 and file[3] updated.
REQ-046 iss_ready=0 for 3 cycles -> iss_* stable, dec_ready=0, no alloc_valid; rob_full=1 -> dec_ready=0.
REQ-047 Dispatch rd=0 with dec_wr=1 and commit wb_rd=0 -> x0 still reads 0 with q=INVALID.
